// File: rtl/alu_dispatcher_if.sv
// Bundles the command, ALU and result channels of the dispatcher.
// Combinational only; no storage or latency of its own.
// Backpressure is carried by in_ready (commands) and out_ready (results).
interface alu_dispatcher_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    // Command channel from the queue front-end
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_opcode;
    logic [7:0]    in_a;
    logic [7:0]    in_b;

    // ALU operand/opcode/result channel
    logic [15:0]   alu_operands;
    logic [2:0]    alu_opcode;
    logic [7:0]    alu_result;

    // Result channel to the consumer
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_result;
    logic [2:0]    out_opcode;

    // Number of commands waiting in the FIFO
    logic [CW-1:0] count;

    // Environment side: command source, ALU and result consumer
    modport master (
        output in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
        input  in_ready, alu_operands, alu_opcode, out_valid, out_result,
               out_opcode, count
    );

    // Dispatcher side
    modport slave (
        input  in_valid, in_opcode, in_a, in_b, alu_result, out_ready,
        output in_ready, alu_operands, alu_opcode, out_valid, out_result,
               out_opcode, count
    );
endinterface

// File: rtl/alu_dispatcher.sv
// Queues ALU commands in a FIFO and issues them one at a time, returning each result.
// Latency: push into an idle, empty dispatcher -> out_valid ALU_LAT+1 cycles later.
// Backpressure: a held result stalls issue; the FIFO keeps filling until in_ready drops.
module alu_dispatcher #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_dispatcher_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(ALU_LAT);

    typedef struct packed {
        logic [2:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_t;

    // Command storage; contents need no reset because occupancy is tracked by count_q
    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    cmd_t          head;

    state_t        state;
    state_t        state_nxt;
    logic [LW-1:0] lat_cnt;

    logic          push;
    logic          pop;
    logic          capture;
    logic          release_out;
    logic          in_ready_int;

    logic [15:0]   alu_operands_q;
    logic [2:0]    alu_opcode_q;
    logic [7:0]    out_result_q;
    logic [2:0]    out_opcode_q;
    logic          out_valid_q;

    // Ready depends only on occupancy, so a same-cycle pop never frees a slot for a push
    assign in_ready_int = (count_q != CW'(DEPTH));
    assign push         = bus.in_valid && in_ready_int;
    assign head         = mem[rd_ptr];

    // Capture accepted commands at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode: bus.in_opcode, a: bus.in_a, b: bus.in_b};
        end
    end

    // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // State register; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and single-cycle control strobes
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        capture     = 1'b0;
        release_out = 1'b0;
        case (state)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    release_out = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ALU drive and latency counter; operands stay on the bus until the next issue
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_operands_q <= '0;
            alu_opcode_q   <= '0;
            lat_cnt        <= '0;
        end else if (pop) begin
            alu_operands_q <= {head.a, head.b};
            alu_opcode_q   <= head.opcode;
            lat_cnt        <= LW'(ALU_LAT - 1);
        end else if (state == S_WAIT && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LW'(1);
        end
    end

    // Result register; held stable while the consumer withholds out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            out_result_q <= '0;
            out_opcode_q <= '0;
            out_valid_q  <= 1'b0;
        end else if (capture) begin
            out_result_q <= bus.alu_result;
            out_opcode_q <= alu_opcode_q;
            out_valid_q  <= 1'b1;
        end else if (release_out) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready     = in_ready_int;
    assign bus.count        = count_q;
    assign bus.alu_operands = alu_operands_q;
    assign bus.alu_opcode   = alu_opcode_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = out_result_q;
    assign bus.out_opcode   = out_opcode_q;
endmodule
